// File: rtl/mcpu_alu_pipe.sv
// Handshaked MCPU ALU: single-cycle logic/arith/shift ops plus an optional iterative shift-add multiplier.
// Define MCPU_ALU_MUL_EN to build the multiplier; without it opcode 111 completes at once and reports illegal.
module mcpu_alu_pipe #(
    parameter int WORD_SIZE = 8,
    parameter int CMD_SIZE  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CMD_SIZE-1:0]  opcode,
    input  logic [WORD_SIZE-1:0] r1,
    input  logic [WORD_SIZE-1:0] r2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out,
    output logic                 overflow,
    output logic                 zero,
    output logic                 illegal
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DONE = 2'd2;
`ifdef MCPU_ALU_MUL_EN
    localparam logic [1:0] MUL  = 2'd1;
    localparam int CNT_W = $clog2(WORD_SIZE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_SIZE - 1);
`endif

    localparam logic [CMD_SIZE-1:0] OP_AND = CMD_SIZE'(0);
    localparam logic [CMD_SIZE-1:0] OP_OR  = CMD_SIZE'(1);
    localparam logic [CMD_SIZE-1:0] OP_XOR = CMD_SIZE'(2);
    localparam logic [CMD_SIZE-1:0] OP_ADD = CMD_SIZE'(3);
    localparam logic [CMD_SIZE-1:0] OP_SUB = CMD_SIZE'(4);
    localparam logic [CMD_SIZE-1:0] OP_SHL = CMD_SIZE'(5);
    localparam logic [CMD_SIZE-1:0] OP_SHR = CMD_SIZE'(6);
    localparam logic [CMD_SIZE-1:0] OP_MUL = CMD_SIZE'(7);
    localparam logic [WORD_SIZE-1:0] SHIFT_LIM = WORD_SIZE'(WORD_SIZE);

    // Returns {overflow, result} for every single-cycle opcode; MUL and unknowns yield zero.
    function automatic logic [WORD_SIZE:0] alu_eval(
        input logic [CMD_SIZE-1:0]  op,
        input logic [WORD_SIZE-1:0] a,
        input logic [WORD_SIZE-1:0] b
    );
        logic [WORD_SIZE-1:0]     r;
        logic                     v;
        logic signed [WORD_SIZE:0] sum_s;
        logic [2*WORD_SIZE-1:0]   wide;
        r     = '0;
        v     = 1'b0;
        sum_s = '0;
        wide  = '0;
        case (op)
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_ADD: begin
                sum_s = $signed({a[WORD_SIZE-1], a}) + $signed({b[WORD_SIZE-1], b});
                r     = sum_s[WORD_SIZE-1:0];
                v     = sum_s[WORD_SIZE] ^ sum_s[WORD_SIZE-1];
            end
            OP_SUB: begin
                sum_s = $signed({a[WORD_SIZE-1], a}) - $signed({b[WORD_SIZE-1], b});
                r     = sum_s[WORD_SIZE-1:0];
                v     = sum_s[WORD_SIZE] ^ sum_s[WORD_SIZE-1];
            end
            OP_SHL: begin
                if (b >= SHIFT_LIM) begin
                    v = |a;
                end else begin
                    wide = {{WORD_SIZE{1'b0}}, a} << b;
                    r    = wide[WORD_SIZE-1:0];
                    v    = |wide[2*WORD_SIZE-1:WORD_SIZE];
                end
            end
            OP_SHR: r = (b >= SHIFT_LIM) ? '0 : (a >> b);
            default: r = '0;
        endcase
        return {v, r};
    endfunction

    logic [1:0]           state;
    logic                 accept;
    logic                 illegal_op;
    logic [WORD_SIZE:0]   res_p0;

    assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign res_p0    = alu_eval(opcode, r1, r2);

`ifdef MCPU_ALU_MUL_EN
    assign illegal_op = 1'b0;

    logic [2*WORD_SIZE-1:0] acc;
    logic [2*WORD_SIZE-1:0] mcand;
    logic [2*WORD_SIZE-1:0] acc_next;
    logic [WORD_SIZE-1:0]   mplier;
    logic [CNT_W-1:0]       cnt;

    // One multiplier bit per cycle, LSB first; the multiplicand shifts left alongside.
    assign acc_next = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (accept && opcode == OP_MUL) begin
            acc    <= '0;
            mcand  <= {{WORD_SIZE{1'b0}}, r1};
            mplier <= r2;
            cnt    <= '0;
        end else if (state == MUL) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end
`else
    assign illegal_op = (opcode == OP_MUL);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            out      <= '0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            illegal  <= 1'b0;
        end else if (accept) begin
`ifdef MCPU_ALU_MUL_EN
            if (opcode == OP_MUL) begin
                state <= MUL;
            end else
`endif
            begin
                state    <= DONE;
                out      <= res_p0[WORD_SIZE-1:0];
                overflow <= res_p0[WORD_SIZE];
                zero     <= ~|res_p0[WORD_SIZE-1:0];
                illegal  <= illegal_op;
            end
        end else if (state == DONE && out_ready) begin
            state <= IDLE;
`ifdef MCPU_ALU_MUL_EN
        end else if (state == MUL && cnt == CNT_LAST) begin
            // Last iteration folds straight into the result register.
            state    <= DONE;
            out      <= acc_next[WORD_SIZE-1:0];
            overflow <= |acc_next[2*WORD_SIZE-1:WORD_SIZE];
            zero     <= ~|acc_next[WORD_SIZE-1:0];
            illegal  <= 1'b0;
`endif
        end
    end
endmodule

// File: tb/tb_mcpu_alu_pipe.sv
// Bench for mcpu_alu_pipe (WORD_SIZE = 8): directed vectors, reference model with one compare process.
module tb_mcpu_alu_pipe;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] opcode = 3'd0;
    logic [7:0] r1 = 8'd0;
    logic [7:0] r2 = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out;
    logic       overflow;
    logic       zero;
    logic       illegal;

    always #5 clk = ~clk;

    mcpu_alu_pipe #(.WORD_SIZE(8), .CMD_SIZE(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .r1(r1), .r2(r2), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .overflow(overflow), .zero(zero), .illegal(illegal)
    );

    typedef struct {
        logic [7:0] out;
        logic       ovf;
        logic       zero;
        logic       ill;
        int         lat;
        int         acc;
        int         rdy;
        bit         seen;
        bit         has_lit;
        logic [7:0] lout;
        logic       lovf;
        logic       lzero;
        logic       lill;
        int         llat;
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   timeouts = 0;
    int   timeouts_seen = 0;

    logic       lit_en = 1'b0;
    logic [7:0] lit_out = 8'd0;
    logic       lit_ovf = 1'b0;
    logic       lit_zero = 1'b0;
    logic       lit_ill = 1'b0;
    int         lit_lat = 1;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference behaviour from plain integer arithmetic.
    function automatic ent_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        ent_t   e;
        int     ia, ib, sa, sb, s;
        longint p;
        ia = int'(a);
        ib = int'(b);
        sa = (ia >= 128) ? ia - 256 : ia;
        sb = (ib >= 128) ? ib - 256 : ib;
        e.out = 8'd0; e.ovf = 1'b0; e.ill = 1'b0; e.lat = 1;
        e.acc = 0; e.rdy = 0; e.seen = 1'b0; e.has_lit = 1'b0;
        e.lout = 8'd0; e.lovf = 1'b0; e.lzero = 1'b0; e.lill = 1'b0; e.llat = 0;
        case (op)
            3'd0: e.out = a & b;
            3'd1: e.out = a | b;
            3'd2: e.out = a ^ b;
            3'd3: begin
                s = sa + sb;
                e.out = 8'((ia + ib) % 256);
                e.ovf = (s > 127) || (s < -128);
            end
            3'd4: begin
                s = sa - sb;
                e.out = 8'((ia - ib + 256) % 256);
                e.ovf = (s > 127) || (s < -128);
            end
            3'd5: begin
                if (ib >= 8) begin
                    e.out = 8'd0;
                    e.ovf = (ia != 0);
                end else begin
                    p = longint'(ia) * (longint'(1) << ib);
                    e.out = 8'(p % 256);
                    e.ovf = (p > 255);
                end
            end
            3'd6: e.out = (ib >= 8) ? 8'd0 : 8'(ia / (1 << ib));
            default: begin
`ifdef MCPU_ALU_MUL_EN
                p = longint'(ia) * longint'(ib);
                e.out = 8'(p % 256);
                e.ovf = (p > 255);
                e.lat = 9;
`else
                e.out = 8'd0;
                e.ill = 1'b1;
`endif
            end
        endcase
        e.zero = (e.out == 8'd0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        ent_t e;
        logic ev;
        logic er;
        if (timeouts != timeouts_seen) begin
            chk("wait_bound", timeouts, timeouts_seen);
            timeouts_seen = timeouts;
        end
        if (!rst_n) begin
            q.delete();
            chk("rst_out_valid", out_valid, 1'b0);
            chk("rst_out", out, 8'd0);
            chk("rst_overflow", overflow, 1'b0);
            chk("rst_zero", zero, 1'b0);
            chk("rst_illegal", illegal, 1'b0);
        end else begin
            ev = (q.size() > 0) && (cyc >= q[0].rdy);
            er = (q.size() == 0) || (ev && out_ready);
            chk("out_valid", out_valid, ev);
            chk("in_ready", in_ready, er);
            if (ev) begin
                chk("out", out, q[0].out);
                chk("overflow", overflow, q[0].ovf);
                chk("zero", zero, q[0].zero);
                chk("illegal", illegal, q[0].ill);
                if (q[0].has_lit && !q[0].seen) begin
                    chk("lit_out", out, q[0].lout);
                    chk("lit_overflow", overflow, q[0].lovf);
                    chk("lit_zero", zero, q[0].lzero);
                    chk("lit_illegal", illegal, q[0].lill);
                    chk("lit_latency", cyc - q[0].acc, q[0].llat);
                end
                q[0].seen = 1'b1;
                if (out_ready) void'(q.pop_front());
            end
            if (in_valid && er) begin
                e = model(opcode, r1, r2);
                e.acc = cyc;
                e.rdy = cyc + e.lat;
                e.has_lit = lit_en;
                e.lout = lit_out; e.lovf = lit_ovf; e.lzero = lit_zero; e.lill = lit_ill;
                e.llat = lit_lat;
                q.push_back(e);
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int n;
        opcode = op; r1 = a; r2 = b; in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 40);
        if (!in_ready) timeouts++;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int bound);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < bound);
        if (!out_valid) timeouts++;
        @(posedge clk);
        #1;
    endtask

    task automatic op_lit(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eo, input logic eovf, input logic ez,
                          input logic eill, input int lat);
        lit_en = 1'b1; lit_out = eo; lit_ovf = eovf; lit_zero = ez; lit_ill = eill; lit_lat = lat;
        send(op, a, b);
        wait_valid(lat + 5);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        op_lit(3'd3, 8'h04, 8'h04, 8'h08, 1'b0, 1'b0, 1'b0, 1);
        op_lit(3'd2, 8'h09, 8'h09, 8'h00, 1'b0, 1'b1, 1'b0, 1);
        op_lit(3'd3, 8'h7F, 8'h01, 8'h80, 1'b1, 1'b0, 1'b0, 1);
        op_lit(3'd4, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b0, 1);
        op_lit(3'd5, 8'h81, 8'h01, 8'h02, 1'b1, 1'b0, 1'b0, 1);
        op_lit(3'd6, 8'h80, 8'h09, 8'h00, 1'b0, 1'b1, 1'b0, 1);
        op_lit(3'd5, 8'h01, 8'h07, 8'h80, 1'b0, 1'b0, 1'b0, 1);
        op_lit(3'd5, 8'h03, 8'h07, 8'h80, 1'b1, 1'b0, 1'b0, 1);
        op_lit(3'd5, 8'h01, 8'h08, 8'h00, 1'b1, 1'b1, 1'b0, 1);
        op_lit(3'd6, 8'hF0, 8'h04, 8'h0F, 1'b0, 1'b0, 1'b0, 1);
        op_lit(3'd6, 8'h80, 8'h07, 8'h01, 1'b0, 1'b0, 1'b0, 1);
        op_lit(3'd4, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0, 1);
        op_lit(3'd3, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0, 1);
        op_lit(3'd4, 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b0, 1'b0, 1);
        op_lit(3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1);

        // Back-pressure: AND result held, queued OR accepted the cycle out_ready rises.
        out_ready = 1'b0;
        op_lit(3'd0, 8'h0F, 8'h3C, 8'h0C, 1'b0, 1'b0, 1'b0, 1);
        lit_out = 8'h3F; lit_ovf = 1'b0; lit_zero = 1'b0; lit_ill = 1'b0; lit_lat = 1;
        opcode = 3'd1; r1 = 8'h0F; r2 = 8'h3C; in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_valid(5);

        // Back-to-back single-cycle ops with out_ready held high.
        lit_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            opcode = 3'(i % 7);
            r1 = 8'(i * 37 + 5);
            r2 = 8'(i * 91 + 3) & 8'h0F;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset while a result is held in DONE.
        out_ready = 1'b0;
        op_lit(3'd3, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0, 1);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

`ifdef MCPU_ALU_MUL_EN
        op_lit(3'd7, 8'd12, 8'd13, 8'h9C, 1'b0, 1'b0, 1'b0, 9);
        op_lit(3'd7, 8'd16, 8'd16, 8'h00, 1'b1, 1'b1, 1'b0, 9);
        op_lit(3'd7, 8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, 9);
        // Reset mid-multiply discards the operation.
        lit_en = 1'b0;
        send(3'd7, 8'd3, 8'd5);
        @(posedge clk);
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        op_lit(3'd3, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0, 1);
`else
        op_lit(3'd7, 8'h55, 8'h33, 8'h00, 1'b0, 1'b1, 1'b1, 1);
        op_lit(3'd2, 8'h55, 8'h33, 8'h66, 1'b0, 1'b0, 1'b0, 1);
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mcpu_alu_pipe.md
# mcpu_alu_pipe

Handshaked, parametrised successor to the MCPU combinational ALU. It accepts one operation per transaction on a valid/ready input channel. Single-cycle operations and an iterative shift-add multiplier share one output register, which holds the result until the consumer takes it. It sits between the MCPU decode/register-read stage and writeback, and lets a stalled writeback stage back-pressure the ALU.

## Interface
Parameters:
- WORD_SIZE, 8, operand and result width in bits; must be at least 4.
- CMD_SIZE, 3, opcode width; fixed at 3, and other values are unsupported.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  the upstream stage presents an operation.
- in_ready  output  1  the block accepts the operation this cycle.
- opcode  input  CMD_SIZE  operation select.
- r1  input  WORD_SIZE  operand A.
- r2  input  WORD_SIZE  operand B.
- out_valid  output  1  result registers hold an untaken result.
- out_ready  input  1  the consumer takes the result this cycle.
- out  output  WORD_SIZE  result.
- overflow  output  1  overflow flag for the result.
- zero  output  1  set when out == 0.
- illegal  output  1  the opcode is not available in this build.

## Operation
- Accept: an operation is accepted on a cycle where in_valid && in_ready. Operands and opcode are captured on that edge.
- Opcodes:
  - 000 AND: out = r1 & r2.
  - 001 OR: out = r1 | r2.
  - 010 XOR: out = r1 ^ r2.
  - 011 ADD: out = r1 + r2, modulo 2^WORD_SIZE. Overflow is signed overflow: both operand MSBs equal and the result MSB differs.
  - 100 SUB: out = r1 - r2, modulo 2^WORD_SIZE. Overflow is signed overflow: the operand MSBs differ and the result MSB differs from r1's MSB.
  - 101 SHL: out = r1 << r2. Overflow = 1 if any 1 bit is shifted out. If r2 >= WORD_SIZE, out = 0 and overflow = (r1 != 0).
  - 110 SHR: logical shift, out = r1 >> r2. Overflow is always 0. If r2 >= WORD_SIZE, out = 0.
  - 111 MUL: unsigned multiply. out = low WORD_SIZE bits of the product. Overflow = (high WORD_SIZE bits != 0).
- Flags: overflow is 0 for AND, OR, XOR and SHR. zero is computed from the final out for every opcode.
- State machine, with states IDLE, MUL, DONE:
  - IDLE to DONE on accepting a non-MUL opcode.
  - IDLE to MUL on accepting opcode 111.
  - MUL to DONE after WORD_SIZE iterations. Each iteration examines one multiplier bit, LSB first, and conditionally adds the shifted multiplicand into a 2*WORD_SIZE accumulator.
  - DONE to IDLE on out_ready when in_valid is low.
  - DONE to DONE or MUL on out_ready with a simultaneous accept; the new operation chooses the next state.
  - DONE holds while out_ready is low.
- Ready: in_ready = (state == IDLE) || (state == DONE && out_ready). It is 0 throughout MUL.
- Valid: out_valid = (state == DONE). out, overflow, zero and illegal are stable whenever out_valid is 1 and out_ready is 0.

## Timing
- Reset values, applied immediately on rst_n low regardless of clk:
  - state = IDLE.
  - out = 0, overflow = 0, zero = 0, illegal = 0, out_valid = 0.
  - The multiplier accumulator and counter are 0.
  - in_ready is 1 once reset is released.
- Single-cycle ops: out_valid rises on the edge after the accept, so latency is 1.
- MUL: out_valid rises WORD_SIZE+1 edges after the accept.
- Throughput: one single-cycle op per clock when out_ready is held high (back-to-back via the DONE to DONE path).
- Reset mid-MUL or while in DONE: the operation is discarded, with no partial result and no out_valid.
- in_valid while in_ready = 0 is ignored. Upstream must hold the operation until accepted.

## Configuration
- MCPU_ALU_MUL_EN defined: opcode 111 performs the iterative multiply and the MUL state exists.
- MCPU_ALU_MUL_EN undefined:
  - Opcode 111 completes as a single-cycle op with out = 0, overflow = 0, zero = 1, illegal = 1.
  - The MUL state and the accumulator are not synthesised.
- illegal is 0 for every opcode other than this one.

## Test plan
All scenarios use WORD_SIZE = 8.
- Reset and ADD: assert rst_n = 0, then release. Expect out_valid = 0 and in_ready = 1. Then ADD r1 = 4, r2 = 4. One cycle later expect out = 8, overflow = 0, zero = 0.
- XOR and signed ADD: XOR r1 = 9, r2 = 9 gives out = 0, zero = 1. ADD r1 = 0x7F, r2 = 1 gives out = 0x80, overflow = 1. SUB r1 = 0x80, r2 = 1 gives out = 0x7F, overflow = 1.
- Back-pressure and back-to-back: AND 0x0F/0x3C, then OR 0x0F/0x3C, with out_ready low for 3 cycles.
  - Expect out = 0x0C held with in_ready = 0.
  - On out_ready high, the second op is accepted in the same cycle.
  - The next result is 0x3F.
- Shifts: SHL r1 = 0x81, r2 = 1 gives out = 0x02, overflow = 1. SHR r1 = 0x80, r2 = 9 gives out = 0, zero = 1.
- MUL (with MCPU_ALU_MUL_EN):
  - 12 × 13: out = 0x9C, overflow = 0, out_valid 9 cycles after accept, in_ready = 0 in between.
  - 16 × 16: out = 0x00, overflow = 1, zero = 1.
- Abort and disabled MUL:
  - rst_n pulsed low mid-MUL: expect no out_valid, and in_ready = 1 after release.
  - Without the macro, opcode 111 gives illegal = 1 and out = 0 after 1 cycle.
